// File: rtl/mpc_coef_rom_stream.sv
// Coefficient ROM with a registered random-access read port and an
// independent streaming read port. The stream replays consecutive entries
// from a base address under valid/ready flow control, using a 2-entry
// output buffer so one read can always be in flight.
module mpc_coef_rom_stream #(
    parameter int DataWidth    = 17,
    parameter int AddressWidth = 3,
    parameter int AddressRange = 6,
    parameter int LenWidth     = 8,
    parameter logic [DataWidth-1:0] EvenWord = 'h08000,
    parameter logic [DataWidth-1:0] OddWord  = 'h19220
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [AddressWidth-1:0] address0,
    input  logic                    ce0,
    output logic [DataWidth-1:0]    q0,
    input  logic                    start,
    input  logic [AddressWidth-1:0] base,
    input  logic [LenWidth-1:0]     len,
    input  logic                    abort,
    output logic [DataWidth-1:0]    s_data,
    output logic                    s_valid,
    input  logic                    s_ready,
    output logic                    s_last,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [AddressWidth-1:0] LastAddr = AddressWidth'(AddressRange - 1);

    // Entries alternate between two words; out-of-range addresses read as zero.
    function automatic logic [DataWidth-1:0] rom_word(input logic [AddressWidth-1:0] a);
        if (32'(a) >= AddressRange) return '0;
        return a[0] ? OddWord : EvenWord;
    endfunction

    state_t                state_q, state_d;
    logic [DataWidth-1:0]  q0_q, q0_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic [LenWidth-1:0]   len_q, len_d;
    logic [LenWidth-1:0]   issue_q, issue_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [DataWidth-1:0]  rd_data_q, rd_data_d;
    logic                  rd_last_q, rd_last_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [DataWidth-1:0]  buf0_data_q, buf0_data_d;
    logic                  buf0_last_q, buf0_last_d;
    logic [DataWidth-1:0]  buf1_data_q, buf1_data_d;
    logic                  buf1_last_q, buf1_last_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occ;

    // Random-access port: load on enable, otherwise hold.
    always_comb begin
        q0_d = q0_q;
        if (ce0) q0_d = rom_word(address0);
    end

    // Stream control: FSM, read issue with credit, output buffer update.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        issue_d     = issue_q;
        rd_vld_d    = 1'b0;
        rd_data_d   = rd_data_q;
        rd_last_d   = rd_last_q;
        cnt_d       = cnt_q;
        buf0_data_d = buf0_data_q;
        buf0_last_d = buf0_last_q;
        buf1_data_d = buf1_data_q;
        buf1_last_d = buf1_last_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        pop = (cnt_q != 2'd0) && s_ready;
        // Occupancy the buffer would have if no new read were issued now.
        occ = {1'b0, cnt_q} + {2'b00, rd_vld_q} - {2'b00, pop};
        issue = (state_q == RUN) && (occ < 3'd2);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (32'(base) >= AddressRange) begin
                        err_d = 1'b1;
                    end else if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d  = base;
                        len_d   = len;
                        issue_d = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    rd_vld_d  = 1'b1;
                    rd_data_d = rom_word(addr_q);
                    rd_last_d = (issue_q == len_q - LenWidth'(1));
                    addr_d    = (addr_q == LastAddr) ? '0 : addr_q + AddressWidth'(1);
                    issue_d   = issue_q + LenWidth'(1);
                    if (issue_q == len_q - LenWidth'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && buf0_last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The read returning this cycle lands in the head if it is free,
        // otherwise in the skid entry.
        case (cnt_q)
            2'd0: begin
                if (rd_vld_q) begin
                    buf0_data_d = rd_data_q;
                    buf0_last_d = rd_last_q;
                    cnt_d       = 2'd1;
                end
            end
            2'd1: begin
                if (rd_vld_q && pop) begin
                    buf0_data_d = rd_data_q;
                    buf0_last_d = rd_last_q;
                end else if (rd_vld_q) begin
                    buf1_data_d = rd_data_q;
                    buf1_last_d = rd_last_q;
                    cnt_d       = 2'd2;
                end else if (pop) begin
                    cnt_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    buf0_data_d = buf1_data_q;
                    buf0_last_d = buf1_last_q;
                    if (rd_vld_q) begin
                        buf1_data_d = rd_data_q;
                        buf1_last_d = rd_last_q;
                    end else begin
                        cnt_d = 2'd1;
                    end
                end
            end
        endcase

        // Cancel discards everything and wins over a simultaneous start.
        if (abort) begin
            state_d  = IDLE;
            rd_vld_d = 1'b0;
            cnt_d    = 2'd0;
            done_d   = 1'b0;
            err_d    = 1'b0;
        end
    end

    // Control and visible output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            q0_q        <= '0;
            rd_vld_q    <= 1'b0;
            cnt_q       <= 2'd0;
            buf0_data_q <= '0;
            buf0_last_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q0_q        <= q0_d;
            rd_vld_q    <= rd_vld_d;
            cnt_q       <= cnt_d;
            buf0_data_q <= buf0_data_d;
            buf0_last_q <= buf0_last_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Datapath registers; only meaningful when qualified by control state.
    always_ff @(posedge clk) begin
        addr_q      <= addr_d;
        len_q       <= len_d;
        issue_q     <= issue_d;
        rd_data_q   <= rd_data_d;
        rd_last_q   <= rd_last_d;
        buf1_data_q <= buf1_data_d;
        buf1_last_q <= buf1_last_d;
    end

    assign q0      = q0_q;
    assign s_data  = buf0_data_q;
    assign s_valid = (cnt_q != 2'd0);
    assign s_last  = buf0_last_q && (cnt_q != 2'd0);
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mpc_coef_rom_stream.sv
// Bench for mpc_coef_rom_stream: table-driven random-access checks,
// hand-written stream corner cases, and randomized streams with random
// back-pressure and concurrent random-access traffic.
module tb_mpc_coef_rom_stream;

    localparam int RANGE = 6;
    localparam logic [16:0] EVEN = 17'h08000;
    localparam logic [16:0] ODD  = 17'h19220;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address0;
    logic        ce0;
    logic [16:0] q0;
    logic        start;
    logic [2:0]  base;
    logic [7:0]  len;
    logic        abort;
    logic [16:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    logic [16:0] exp_q0 = '0;

    mpc_coef_rom_stream dut (
        .clk(clk), .reset(reset), .address0(address0), .ce0(ce0), .q0(q0),
        .start(start), .base(base), .len(len), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] ref_word(input int a);
        if (a >= RANGE) return '0;
        return (a % 2 == 1) ? ODD : EVEN;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Check q0 against the previous cycle's request, then issue a random one.
    task automatic ra_step();
        int a;
        logic c;
        chk("q0_concurrent", q0, exp_q0);
        a = $urandom_range(0, 7);
        c = 1'($urandom_range(0, 1));
        address0 = 3'(a);
        ce0 = c;
        if (c) exp_q0 = ref_word(a);
    endtask

    // Runs one stream; mode 0 = ready always, 1 = fixed toggle, 2 = random.
    task automatic run_stream(input int b, input int l, input int mode, input int abort_at);
        logic [16:0] exp_d[$];
        bit pat[6] = '{1, 0, 0, 1, 0, 1};
        int n = 0;
        int i = 0;
        int tg = 0;
        int budget;
        bit finished = 0, last_acc = 0, ab_pend = 0;
        logic prev_stall = 0;
        logic [16:0] prev_data = '0;
        logic prev_last = 0;
        logic rdy;
        for (int k = 0; k < l; k++) exp_d.push_back(ref_word((b + k) % RANGE));
        budget = l * 6 + 20;
        start = 1'b1; base = 3'(b); len = 8'(l); s_ready = 1'b0;
        ra_step();
        @(negedge clk);
        while (!finished && i < budget) begin
            start = 1'b0;
            ra_step();
            if (ab_pend) begin
                chk("abort_valid", s_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                abort = 1'b0;
                finished = 1;
            end else if (last_acc) begin
                chk("done_pulse", done, 1);
                chk("done_busy", busy, 0);
                chk("done_valid", s_valid, 0);
                if (mode == 0) chk("done_cycle", i, l + 2);
                finished = 1;
            end else begin
                chk("run_done", done, 0);
                chk("run_busy", busy, 1);
                chk("run_err", err, 0);
                if (i < 2) chk("early_valid", s_valid, 0);
                if (i == 2) chk("first_valid", s_valid, 1);
                if (mode == 0 && i >= 2) chk("stream_gapless", s_valid, 1);
                if (prev_stall) begin
                    chk("stall_valid", s_valid, 1);
                    chk("stall_data", s_data, prev_data);
                    chk("stall_last", s_last, prev_last);
                end
                case (mode)
                    0: rdy = 1'b1;
                    1: begin rdy = pat[tg % 6]; tg++; end
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                if (abort_at >= 0 && n == abort_at) begin
                    abort = 1'b1;
                    rdy = 1'b0;
                    ab_pend = 1;
                end
                if (i == 4) begin
                    start = 1'b1;
                    base = 3'($urandom_range(0, 7));
                    len = 8'($urandom);
                end
                s_ready = rdy;
                if (s_valid && rdy) begin
                    chk("beat_data", s_data, exp_d[n]);
                    chk("beat_last", s_last, (n == l - 1));
                    n++;
                    if (n == l) last_acc = 1;
                end
                prev_stall = s_valid && !rdy;
                prev_data = s_data;
                prev_last = s_last;
            end
            @(negedge clk);
            i++;
        end
        if (!finished) chk("stream_timeout", 0, 1);
        start = 1'b0; abort = 1'b0; s_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            ra_step();
            chk("idle_done", done, 0);
            chk("idle_valid", s_valid, 0);
            chk("idle_busy", busy, 0);
            @(negedge clk);
        end
        ce0 = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic        ce;
        logic [16:0] exp;
    } ra_vec_t;

    initial begin
        ra_vec_t tbl[10];
        tbl[0] = '{3'd0, 1'b1, 17'h08000};
        tbl[1] = '{3'd1, 1'b1, 17'h19220};
        tbl[2] = '{3'd5, 1'b1, 17'h19220};
        tbl[3] = '{3'd6, 1'b1, 17'h00000};
        tbl[4] = '{3'd3, 1'b0, 17'h00000};
        tbl[5] = '{3'd2, 1'b1, 17'h08000};
        tbl[6] = '{3'd4, 1'b0, 17'h08000};
        tbl[7] = '{3'd7, 1'b1, 17'h00000};
        tbl[8] = '{3'd3, 1'b1, 17'h19220};
        tbl[9] = '{3'd4, 1'b1, 17'h08000};

        reset = 1'b1; address0 = '0; ce0 = 1'b0; start = 1'b0; base = '0;
        len = '0; abort = 1'b0; s_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_q0", q0, 0);
        chk("rst_s_data", s_data, 0);
        chk("rst_s_valid", s_valid, 0);
        chk("rst_s_last", s_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;

        foreach (tbl[t]) begin
            address0 = tbl[t].addr;
            ce0 = tbl[t].ce;
            @(negedge clk);
            chk("ra_table", q0, tbl[t].exp);
        end
        exp_q0 = tbl[9].exp;
        ce0 = 1'b0;

        // Zero-length stream: done only.
        start = 1'b1; base = 3'd2; len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        chk("len0_valid", s_valid, 0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("len0_after_done", done, 0);
            chk("len0_after_valid", s_valid, 0);
        end

        // Out-of-range base: err only.
        start = 1'b1; base = 3'd6; len = 8'd3;
        @(negedge clk);
        start = 1'b0;
        chk("badbase_err", err, 1);
        chk("badbase_busy", busy, 0);
        chk("badbase_done", done, 0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("badbase_after_err", err, 0);
            chk("badbase_after_busy", busy, 0);
            chk("badbase_after_valid", s_valid, 0);
        end

        run_stream(4, 5, 0, -1);
        run_stream(4, 5, 1, -1);
        run_stream(0, 20, 0, 3);
        run_stream(1, 2, 0, -1);
        run_stream(5, 1, 0, -1);
        run_stream(3, 255, 2, -1);
        for (int r = 0; r < 8; r++)
            run_stream($urandom_range(0, RANGE - 1), $urandom_range(1, 25), 2, -1);
        run_stream(2, 30, 2, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
